// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port framebuffer arbiter; scanout reads always win,
// two game-logic writers share the remaining cycles round-robin.
module vga_fb_arbiter #(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 8,
    parameter int VBLANK_ONLY = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pix_stb,
    input  logic              i_blanking,
    input  logic              i_animate,
    input  logic [9:0]        i_x,
    input  logic [8:0]        i_y,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_pix_data,
    output logic              o_pix_valid,
    output logic [7:0]        o_frame
);
    typedef enum logic [1:0] {IDLE, READ, WR0, WR1} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        frame_q;
    logic              valid_q, open_q, open_d, prio1_q, prio1_d;
    logic              slot, wopen, elig0, elig1, take0, take1, unused_ok;

    assign unused_ok = ^{i_x[1:0], i_y[1:0]};

    always_comb begin
        slot    = i_pix_stb && !i_blanking;
        wopen   = (VBLANK_ONLY == 0) || open_q;
        // a writer granted this cycle is still holding its old request
        elig0   = !slot && wopen && i_req0 && state_q != WR0;
        elig1   = !slot && wopen && i_req1 && state_q != WR1;
        take0   = elig0 && !(elig1 && prio1_q);
        take1   = elig1 && !take0;
        state_d = slot ? READ : take0 ? WR0 : take1 ? WR1 : IDLE;
        addr_d  = slot ? ADDR_W'({i_y[8:2], i_x[9:2]}) : take0 ? i_addr0 : take1 ? i_addr1 : addr_q;
        wdata_d = take0 ? i_wdata0 : take1 ? i_wdata1 : wdata_q;
        prio1_d = take0 ? 1'b1 : take1 ? 1'b0 : prio1_q;
        open_d  = i_animate ? 1'b1 : slot ? 1'b0 : open_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            frame_q <= '0;
            valid_q <= 1'b0;
            open_q  <= 1'b0;
            prio1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            frame_q <= frame_q + 8'(i_animate);
            valid_q <= state_q == READ;
            open_q  <= open_d;
            prio1_q <= prio1_d;
        end
    end

    assign o_gnt0      = state_q == WR0;
    assign o_gnt1      = state_q == WR1;
    assign o_mem_we    = o_gnt0 || o_gnt1;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_pix_valid = valid_q;
    assign o_pix_data  = valid_q ? i_mem_rdata : '0;
    assign o_frame     = frame_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: two arbiters (VBLANK_ONLY 0 and 1) checked every cycle
// against a rule-level model, plus directed literal scenarios.
module tb_vga_fb_arbiter;
    localparam int AW = 15;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, stb, blank, anim;
    logic [9:0]    x;
    logic [8:0]    y;
    logic [DW-1:0] rdata;
    logic          req   [2][2];
    logic [AW-1:0] addr  [2][2];
    logic [DW-1:0] wdata [2][2];
    logic          gnt0[2], gnt1[2], we[2], pvalid[2];
    logic [AW-1:0] maddr[2];
    logic [DW-1:0] mwdata[2], pdata[2];
    logic [7:0]    frame[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .VBLANK_ONLY(g)) u_dut (
            .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_blanking(blank), .i_animate(anim),
            .i_x(x), .i_y(y), .i_req0(req[g][0]), .i_req1(req[g][1]),
            .i_addr0(addr[g][0]), .i_addr1(addr[g][1]), .i_wdata0(wdata[g][0]), .i_wdata1(wdata[g][1]),
            .o_gnt0(gnt0[g]), .o_gnt1(gnt1[g]), .o_mem_addr(maddr[g]), .o_mem_we(we[g]),
            .o_mem_wdata(mwdata[g]), .i_mem_rdata(rdata), .o_pix_data(pdata[g]),
            .o_pix_valid(pvalid[g]), .o_frame(frame[g])
        );
    end

    int checks = 0;
    int errors = 0;
    bit run = 0;
    bit auto_req = 0;

    // model: expected outputs after the most recent clock edge
    bit            m_g0[2], m_g1[2], m_valid[2], m_read[2], m_open[2], m_pref1[2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_wd[2];
    int            m_frame[2];

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
        end
    endtask

    task automatic model_update();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_g0[d] = 0; m_g1[d] = 0; m_valid[d] = 0; m_read[d] = 0;
                m_open[d] = 0; m_pref1[d] = 0; m_addr[d] = '0; m_wd[d] = '0; m_frame[d] = 0;
            end else begin
                bit slot, open, e0, e1, w0, w1;
                slot = stb && !blank;
                open = (d == 0) || m_open[d];
                e0 = !slot && open && req[d][0] && !m_g0[d];
                e1 = !slot && open && req[d][1] && !m_g1[d];
                w0 = e0 && !(e1 && m_pref1[d]);
                w1 = e1 && !w0;
                m_valid[d] = m_read[d];
                m_read[d] = slot;
                if (slot) m_addr[d] = AW'(int'(y) / 4 * 256 + int'(x) / 4);
                else if (w0) begin m_addr[d] = addr[d][0]; m_wd[d] = wdata[d][0]; end
                else if (w1) begin m_addr[d] = addr[d][1]; m_wd[d] = wdata[d][1]; end
                if (w0) m_pref1[d] = 1;
                if (w1) m_pref1[d] = 0;
                m_g0[d] = w0;
                m_g1[d] = w1;
                if (anim) m_open[d] = 1;
                else if (slot) m_open[d] = 0;
                m_frame[d] = (m_frame[d] + int'(anim)) % 256;
            end
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("grant_dut%0d", d), 64'({gnt0[d], gnt1[d], we[d]}),
                    64'({m_g0[d], m_g1[d], m_g0[d] | m_g1[d]}));
                chk($sformatf("mem_addr_dut%0d", d), 64'(maddr[d]), 64'(m_addr[d]));
                chk($sformatf("mem_wdata_dut%0d", d), 64'(mwdata[d]), 64'(m_wd[d]));
                chk($sformatf("pix_dut%0d", d), 64'({pvalid[d], pdata[d]}),
                    64'({m_valid[d], m_valid[d] ? rdata : 8'h00}));
                chk($sformatf("frame_dut%0d", d), 64'(frame[d]), 64'(m_frame[d]));
            end
        end
    end

    task automatic tick();
        model_update();
        @(negedge clk);
        #1;
        if (auto_req)
            for (int d = 0; d < 2; d++)
                for (int r = 0; r < 2; r++) begin
                    if (req[d][r]) begin
                        if (r == 0 ? gnt0[d] : gnt1[d]) begin
                            req[d][r] = 1'($urandom);
                            addr[d][r] = AW'($urandom);
                            wdata[d][r] = DW'($urandom);
                        end
                    end else if ($urandom_range(0, 3) == 0) begin
                        req[d][r] = 1'b1;
                        addr[d][r] = AW'($urandom);
                        wdata[d][r] = DW'($urandom);
                    end
                end
    endtask

    task automatic set_req(input int d, input int r, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] w);
        req[d][r] = v;
        addr[d][r] = a;
        wdata[d][r] = w;
    endtask

    task automatic clear_reqs();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 2; r++) set_req(d, r, 1'b0, '0, '0);
    endtask

    initial begin
        int seen, cnt, h, v;
        rst = 1; stb = 0; blank = 1; anim = 0; x = '0; y = '0; rdata = '0;
        clear_reqs();
        tick();
        tick();
        run = 1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_outputs", 64'({gnt0[d], gnt1[d], we[d], pvalid[d], pdata[d]}), 64'(0));
            chk("reset_addr_frame", 64'({maddr[d], mwdata[d], frame[d]}), 64'(0));
        end

        // active pixel read beats two pending writers
        rst = 0; stb = 1; blank = 0; x = 10'd100; y = 9'd40; rdata = 8'h5A;
        for (int d = 0; d < 2; d++) begin
            set_req(d, 0, 1'b1, 15'h0123, 8'h01);
            set_req(d, 1, 1'b1, 15'h0456, 8'h02);
        end
        tick();
        chk("read_addr", 64'(maddr[0]), 64'(15'h0A19));
        chk("read_no_write", 64'({we[0], gnt0[0], gnt1[0]}), 64'(0));
        stb = 0; blank = 1;
        clear_reqs();
        tick();
        chk("read_pixel", 64'({pvalid[0], pdata[0]}), 64'({1'b1, 8'h5A}));

        // both writers held during blanking after reset alternate 0,1,0,...
        rst = 1;
        tick();
        rst = 0; stb = 1;
        for (int d = 0; d < 2; d++) begin
            set_req(d, 0, 1'b1, 15'h0111, 8'h11);
            set_req(d, 1, 1'b1, 15'h2222, 8'h22);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("alt_grants", 64'({gnt0[0], gnt1[0], we[0]}), 64'({k % 2 == 0, k % 2 == 1, 1'b1}));
            chk("alt_addr_data", 64'({maddr[0], mwdata[0]}),
                k % 2 == 0 ? 64'({15'h0111, 8'h11}) : 64'({15'h2222, 8'h22}));
            chk("vblank_closed", 64'({gnt0[1], gnt1[1]}), 64'(0));
        end
        clear_reqs();
        tick();

        // vblank-only writer: blocked until animate, cut off by next scanout slot
        set_req(1, 0, 1'b1, 15'h0333, 8'h33);
        for (int k = 0; k < 8; k++) begin
            stb = 1'(k % 2);
            tick();
            chk("hblank_no_grant", 64'(gnt0[1]), 64'(0));
        end
        stb = 0; anim = 1;
        tick();
        anim = 0;
        seen = int'(gnt0[1]);
        tick();
        seen += int'(gnt0[1]);
        chk("animate_opens_window", 64'(seen), 64'(1));
        chk("animate_frame", 64'(frame[1]), 64'(1));
        for (int k = 0; k < 3; k++) tick();
        stb = 1; blank = 0;
        tick();
        stb = 0; blank = 1;
        cnt = int'(gnt0[1]);
        for (int k = 0; k < 4; k++) begin
            tick();
            cnt += int'(gnt0[1]);
        end
        chk("window_closed_after_slot", 64'(cnt), 64'(0));
        clear_reqs();
        tick();

        // frame counter wraps; animate coincident with a request
        rst = 1;
        tick();
        rst = 0;
        for (int k = 0; k < 255; k++) begin
            anim = 1;
            tick();
            anim = 0;
            tick();
        end
        chk("frame_255", 64'(frame[0]), 64'(255));
        anim = 1;
        set_req(0, 0, 1'b1, 15'h0444, 8'h44);
        tick();
        anim = 0;
        chk("frame_wrap", 64'({frame[0], frame[1]}), 64'(0));
        chk("anim_and_grant", 64'({gnt0[0], we[0], maddr[0], mwdata[0]}), 64'({2'b11, 15'h0444, 8'h44}));
        clear_reqs();
        tick();

        // reset in the cycle a winner is chosen
        anim = 1;
        tick();
        anim = 0;
        rst = 1;
        set_req(0, 0, 1'b1, 15'h0777, 8'h77);
        tick();
        chk("reset_kills_grant", 64'({gnt0[0], gnt1[0], we[0], frame[0]}), 64'(0));
        rst = 0;
        set_req(0, 0, 1'b0, '0, '0);
        set_req(0, 1, 1'b1, 15'h0555, 8'h55);
        tick();
        chk("post_reset_gnt1", 64'({gnt0[0], gnt1[0], maddr[0], mwdata[0]}), 64'({2'b01, 15'h0555, 8'h55}));
        clear_reqs();
        tick();

        // randomized traffic on a compact 12x8 raster, 8x6 active
        auto_req = 1;
        h = 0;
        v = 0;
        for (int n = 0; n < 4000; n++) begin
            rst = $urandom_range(0, 599) == 0;
            stb = 1'($urandom);
            blank = h >= 8 || v >= 6;
            anim = stb && h == 8 && v == 5;
            x = 10'($urandom);
            y = 9'($urandom);
            rdata = DW'($urandom);
            tick();
            if (stb) begin
                h = (h + 1) % 12;
                if (h == 0) v = (v + 1) % 8;
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
